player_motion_ctrl: RTL and testbench
=====================================

// Module: player_motion_ctrl
// PURPOSE
//   Consumer side of the direction interface driven by button_controller: takes the latched
//   one-hot up/down/left/right_pressed levels and moves a player position across a grid at a
//   fixed step rate. Sits between button_controller and the game/VGA renderer.
//   Filters illegal 180-degree reversals and handles edge wrap or clamp.
// PARAMETERS
//   CLK_HZ   100_000_000  input clock frequency
//   STEP_HZ  8            position steps per second; TICKS = CLK_HZ/STEP_HZ (>= 2)
//   GRID_W   40           grid columns; pos_x range 0..GRID_W-1
//   GRID_H   30           grid rows; pos_y range 0..GRID_H-1
//   START_X  20           pos_x after reset
//   START_Y  15           pos_y after reset
//   WRAP     1            1 = wrap at edges, 0 = clamp at edges and flag hit_wall
// PORTS
//   clk            in   1              system clock (100 MHz)
//   reset          in   1              synchronous, active-high
//   enable         in   1              1 = run, 0 = pause (position frozen)
//   up_pressed     in   1              direction request levels from button_controller
//   down_pressed   in   1
//   left_pressed   in   1
//   right_pressed  in   1
//   pos_x          out  $clog2(GRID_W) current column
//   pos_y          out  $clog2(GRID_H) current row
//   dir            out  2              applied direction: UP=00 DOWN=01 LEFT=10 RIGHT=11
//   moving         out  1              1 while state == MOVING
//   step_pulse     out  1              1-cycle strobe on each position update
//   hit_wall       out  1              1-cycle strobe when WRAP=0 and a step is blocked
// BEHAVIOUR
//   Clock is clk; reset is synchronous and active-high, named reset.
//   Reset (any cycle, incl. mid-step): pos=(START_X,START_Y), dir=RIGHT, pend_dir=RIGHT,
//     tick counter=0, state=IDLE, moving/step_pulse/hit_wall=0.
//   Request decode: if several inputs high, priority UP>DOWN>LEFT>RIGHT; none high = no request.
//   pend_dir: in IDLE any request loads it; in MOVING/PAUSED a request loads it unless it is
//     the exact reverse of dir (applied, not pending) -> ignored. Re-request of same dir = no-op.
//   FSM: IDLE --request & enable--> MOVING (counter starts from 0 next cycle).
//        MOVING --!enable--> PAUSED; PAUSED --enable--> MOVING. Counter holds while PAUSED.
//        IDLE ignores requests while !enable.
//   Tick: counter runs 0..TICKS-1 in MOVING only; at count TICKS-1 it wraps to 0 and on that
//     edge: dir<=pend_dir, pos advances one cell in pend_dir, step_pulse=1 next cycle together
//     with new pos/dir (registered; no combinational paths input->output).
//   First step occurs TICKS cycles after entering MOVING.
//   Moves: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1.
//   WRAP=1: x=GRID_W-1 RIGHT -> 0; x=0 LEFT -> GRID_W-1; same for y with GRID_H.
//     step_pulse still asserts on a wrap step; hit_wall never asserts.
//   WRAP=0: blocked step leaves pos unchanged, dir still updates, hit_wall=1 and step_pulse=0
//     that cycle; state stays MOVING.
//   enable falling in the same cycle as a tick: tick takes effect, then PAUSED.
//   pos never leaves its legal range; widths exact, no modulo arithmetic on non-power-of-2.
// STRUCTURE
//   game_pkg: DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT localparams, FSM state encodings
//     (IDLE/MOVING/PAUSED), default GRID_W/GRID_H; shared with renderer and button path.
//   Sub-module step_tick_gen (params CLK_HZ, STEP_HZ; ports clk, reset, run, tick):
//     counter with hold-when-!run; FSM, direction filter and position datapath stay here.
// TESTING (bench params CLK_HZ=100, STEP_HZ=10 -> TICKS=10, GRID 8x8, START 4,4)
//   Reset, right_pressed 1 cycle -> moving=1; step_pulse 10 cycles later, pos=(5,4), dir=11.
//   Moving RIGHT, press left -> ignored, dir stays 11; press up -> next step pos y-1, dir=00.
//   WRAP=1, pos x=7 moving RIGHT -> next step pos_x=0, step_pulse=1, hit_wall=0.
//   WRAP=0, pos y=0 moving UP -> hit_wall=1, step_pulse=0, pos_y stays 0, moving=1.
//   enable=0 at count 5 for 20 cycles -> no steps, pos frozen; enable=1 -> step after 5 more.
//   up+left+right high together in IDLE -> dir=00 applied; reset mid-count -> pos=(4,4), IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: direction codes, motion FSM states and default grid size.
// Used by the motion controller, the renderer and the button path.
package game_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int DEFAULT_GRID_W = 40;
  localparam int DEFAULT_GRID_H = 30;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MOVING = 2'b01,
    ST_PAUSED = 2'b10
  } motion_state_t;

  // Opposite directions differ only in the low bit of the encoding.
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step-rate divider: produces a one-cycle tick every CLK_HZ/STEP_HZ cycles of run,
// holding its count while run is low.
module step_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int STEP_HZ = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int TICKS = CLK_HZ / STEP_HZ;
  localparam int CW    = $clog2(TICKS);
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (run) begin
      if (count == LAST) count <= '0;
      else               count <= count + CW'(1);
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/player_motion_ctrl.sv
// Moves a player position across a grid at a fixed step rate from latched direction
// requests, rejecting 180-degree reversals and wrapping or clamping at the edges.
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int STEP_HZ = 8,
  parameter int GRID_W  = DEFAULT_GRID_W,
  parameter int GRID_H  = DEFAULT_GRID_H,
  parameter int START_X = 20,
  parameter int START_Y = 15,
  parameter int WRAP    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      up_pressed,
  input  logic                      down_pressed,
  input  logic                      left_pressed,
  input  logic                      right_pressed,
  output logic [$clog2(GRID_W)-1:0] pos_x,
  output logic [$clog2(GRID_H)-1:0] pos_y,
  output logic [1:0]                dir,
  output logic                      moving,
  output logic                      step_pulse,
  output logic                      hit_wall
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);

  motion_state_t state, state_next;
  logic [1:0]    pend_dir;
  logic [1:0]    req_dir;
  logic          req_valid;
  logic          run;
  logic          tick;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          blocked;

  step_tick_gen #(.CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    if      (up_pressed)    req_dir = DIR_UP;
    else if (down_pressed)  req_dir = DIR_DOWN;
    else if (left_pressed)  req_dir = DIR_LEFT;
    else if (right_pressed) req_dir = DIR_RIGHT;
    else                    req_valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid && enable) state_next = ST_MOVING;
      ST_MOVING: if (!enable)             state_next = ST_PAUSED;
      ST_PAUSED: if (enable)              state_next = ST_MOVING;
      default:                            state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    moving = (state == ST_MOVING);
    run    = (state == ST_MOVING);
  end

  // Reversal is judged against the applied direction, not the pending one.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_dir <= DIR_RIGHT;
    end else if (req_valid && ((state == ST_IDLE) || (req_dir != reverse_dir(dir)))) begin
      pend_dir <= req_dir;
    end
  end

  always_comb begin
    next_x  = pos_x;
    next_y  = pos_y;
    blocked = 1'b0;
    case (pend_dir)
      DIR_UP: begin
        if (pos_y == '0) begin
          if (WRAP != 0) next_y = YW'(GRID_H - 1);
          else           blocked = 1'b1;
        end else next_y = pos_y - YW'(1);
      end
      DIR_DOWN: begin
        if (pos_y == YW'(GRID_H - 1)) begin
          if (WRAP != 0) next_y = '0;
          else           blocked = 1'b1;
        end else next_y = pos_y + YW'(1);
      end
      DIR_LEFT: begin
        if (pos_x == '0) begin
          if (WRAP != 0) next_x = XW'(GRID_W - 1);
          else           blocked = 1'b1;
        end else next_x = pos_x - XW'(1);
      end
      default: begin
        if (pos_x == XW'(GRID_W - 1)) begin
          if (WRAP != 0) next_x = '0;
          else           blocked = 1'b1;
        end else next_x = pos_x + XW'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x      <= XW'(START_X);
      pos_y      <= YW'(START_Y);
      dir        <= DIR_RIGHT;
      step_pulse <= 1'b0;
      hit_wall   <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      hit_wall   <= 1'b0;
      if (tick) begin
        dir        <= pend_dir;
        pos_x      <= next_x;
        pos_y      <= next_y;
        step_pulse <= !blocked;
        hit_wall   <= blocked;
      end
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Drives a wrapping and a clamping instance with the same stimulus and compares every
// cycle against a cell-arithmetic reference model of the player motion rules.
module tb_player_motion_ctrl;

  localparam int TICKS = 10;
  localparam int GW    = 8;
  localparam int GH    = 8;
  localparam int SX    = 4;
  localparam int SY    = 4;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic       up_pressed, down_pressed, left_pressed, right_pressed;
  logic [2:0] w_pos_x, w_pos_y, c_pos_x, c_pos_y;
  logic [1:0] w_dir, c_dir;
  logic       w_moving, w_step, w_hit, c_moving, c_step, c_hit;

  int total = 0;
  int bad   = 0;

  int mx[2], my[2], mdir[2], mpend[2], mmode[2], mphase[2];
  int mstep[2], mhit[2];

  always #5 clk = ~clk;

  player_motion_ctrl #(.CLK_HZ(100), .STEP_HZ(10), .GRID_W(GW), .GRID_H(GH),
                       .START_X(SX), .START_Y(SY), .WRAP(1)) dut_wrap (
    .clk(clk), .reset(reset), .enable(enable),
    .up_pressed(up_pressed), .down_pressed(down_pressed),
    .left_pressed(left_pressed), .right_pressed(right_pressed),
    .pos_x(w_pos_x), .pos_y(w_pos_y), .dir(w_dir),
    .moving(w_moving), .step_pulse(w_step), .hit_wall(w_hit)
  );

  player_motion_ctrl #(.CLK_HZ(100), .STEP_HZ(10), .GRID_W(GW), .GRID_H(GH),
                       .START_X(SX), .START_Y(SY), .WRAP(0)) dut_clamp (
    .clk(clk), .reset(reset), .enable(enable),
    .up_pressed(up_pressed), .down_pressed(down_pressed),
    .left_pressed(left_pressed), .right_pressed(right_pressed),
    .pos_x(c_pos_x), .pos_y(c_pos_y), .dir(c_dir),
    .moving(c_moving), .step_pulse(c_step), .hit_wall(c_hit)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 paused; phase counts running cycles.
  task automatic modelStep(input int m, input logic [3:0] btn, input logic en, input logic rst);
    int req, newPend, tx, ty;
    int dx[4] = '{0, 0, -1, 1};
    int dy[4] = '{-1, 1, 0, 0};
    bit tickNow, opposite;
    if (rst) begin
      mx[m] = SX; my[m] = SY; mdir[m] = 3; mpend[m] = 3;
      mmode[m] = 0; mphase[m] = 0; mstep[m] = 0; mhit[m] = 0;
      return;
    end
    req = btn[3] ? 0 : btn[2] ? 1 : btn[1] ? 2 : btn[0] ? 3 : -1;
    opposite = (req >= 0) && (req / 2 == mdir[m] / 2) && (req != mdir[m]);
    newPend = mpend[m];
    if (req >= 0 && (mmode[m] == 0 || !opposite)) newPend = req;
    tickNow = (mmode[m] == 1) && (mphase[m] == TICKS - 1);
    mstep[m] = 0;
    mhit[m]  = 0;
    if (mmode[m] == 1) mphase[m] = (mphase[m] + 1) % TICKS;
    if (tickNow) begin
      tx = mx[m] + dx[mpend[m]];
      ty = my[m] + dy[mpend[m]];
      mdir[m] = mpend[m];
      if (m == 0) begin
        mx[m] = (tx + GW) % GW;
        my[m] = (ty + GH) % GH;
        mstep[m] = 1;
      end else if (tx >= 0 && tx < GW && ty >= 0 && ty < GH) begin
        mx[m] = tx; my[m] = ty; mstep[m] = 1;
      end else begin
        mhit[m] = 1;
      end
    end
    case (mmode[m])
      0: if (req >= 0 && en) mmode[m] = 1;
      1: if (!en) mmode[m] = 2;
      default: if (en) mmode[m] = 1;
    endcase
    mpend[m] = newPend;
  endtask

  task automatic checkAll();
    checkOutput("wrap.pos_x", w_pos_x, mx[0]);
    checkOutput("wrap.pos_y", w_pos_y, my[0]);
    checkOutput("wrap.dir", w_dir, mdir[0]);
    checkOutput("wrap.moving", w_moving, mmode[0] == 1);
    checkOutput("wrap.step_pulse", w_step, mstep[0]);
    checkOutput("wrap.hit_wall", w_hit, mhit[0]);
    checkOutput("clamp.pos_x", c_pos_x, mx[1]);
    checkOutput("clamp.pos_y", c_pos_y, my[1]);
    checkOutput("clamp.dir", c_dir, mdir[1]);
    checkOutput("clamp.moving", c_moving, mmode[1] == 1);
    checkOutput("clamp.step_pulse", c_step, mstep[1]);
    checkOutput("clamp.hit_wall", c_hit, mhit[1]);
  endtask

  // btn bits: [3]=up [2]=down [1]=left [0]=right
  task automatic applyStimulus(input logic [3:0] btn, input logic en, input logic rst);
    {up_pressed, down_pressed, left_pressed, right_pressed} = btn;
    enable = en;
    reset  = rst;
    @(posedge clk);
    modelStep(0, btn, en, rst);
    modelStep(1, btn, en, rst);
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input int n, input logic en);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, en, 1'b0);
  endtask

  initial begin
    int lat;
    logic [3:0] btn;
    logic en, rst;
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("reset.pos_x", w_pos_x, 4);
    checkOutput("reset.dir", w_dir, 3);

    $display("[TB] first step latency and reversal filter");
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkOutput("press.moving", w_moving, 1);
    lat = 0;
    while (lat < 40 && w_step !== 1'b1) begin
      applyStimulus(4'b0000, 1'b1, 1'b0);
      lat++;
    end
    checkOutput("first_step_latency", lat, TICKS);
    checkOutput("first_step.pos_x", w_pos_x, 5);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    idleCycles(TICKS, 1'b1);
    checkOutput("reverse_ignored.dir", w_dir, 3);
    applyStimulus(4'b1000, 1'b1, 1'b0);
    idleCycles(2 * TICKS, 1'b1);
    checkOutput("turn_up.dir", w_dir, 0);

    $display("[TB] drive into the top edge, then pause mid-count");
    idleCycles(6 * TICKS, 1'b1);
    checkOutput("clamp_top.pos_y", c_pos_y, 0);
    idleCycles(3, 1'b1);
    idleCycles(20, 1'b0);
    idleCycles(2 * TICKS, 1'b1);

    $display("[TB] priority decode from idle and reset mid-count");
    applyStimulus(4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b1011, 1'b1, 1'b0);
    idleCycles(TICKS + 2, 1'b1);
    checkOutput("priority.dir", w_dir, 0);
    idleCycles(4, 1'b1);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    checkOutput("mid_reset.pos_y", w_pos_y, 4);

    $display("[TB] randomized run");
    for (int i = 0; i < 3000; i++) begin
      btn = 4'b0000;
      for (int b = 0; b < 4; b++) btn[b] = ($urandom_range(0, 15) == 0);
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 499) == 0);
      applyStimulus(btn, en, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
